// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_pkg
//  Description : Shared types for the kernel window builder (FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    // Top-level control state: idle until a valid configuration arrives
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : window_pkg
`default_nettype wire

// File: rtl/window_pos.sv
`default_nettype none
// ============================================================================
//  Module      : window_pos
//  Description : Column/row position tracker for the kernel window. Counts
//                accepted beats across the image line and the frame, and
//                decodes whether the current beat completes a window lying
//                fully inside one line (emit) and whether it is the last
//                window of the frame (last).
//  Revision    : 1.0 - initial release
// ============================================================================
module window_pos
    import window_pkg::*;
#(
    parameter int HEIGHT_NB  = 3,
    parameter int WIDTH_NB   = 3,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_beat,
    input  logic [MEM_AWIDTH-1:0] i_width,
    input  logic [MEM_AWIDTH-1:0] i_height,
    output logic                  o_emit,
    output logic                  o_last
);

    localparam logic [MEM_AWIDTH-1:0] c_ONE        = MEM_AWIDTH'(1);
    localparam logic [MEM_AWIDTH-1:0] c_FIRST_EMIT = MEM_AWIDTH'(WIDTH_NB - 1);
    localparam logic [MEM_AWIDTH-1:0] c_HEIGHT_NB  = MEM_AWIDTH'(HEIGHT_NB);

    logic [MEM_AWIDTH-1:0] r_col_cnt;
    logic [MEM_AWIDTH-1:0] r_row_cnt;
    logic                  w_col_end;
    logic                  w_row_end;

    // The first upstream column of a frame already sits on image row
    // HEIGHT_NB-1, so the last counted row is height-HEIGHT_NB.
    assign w_col_end = (r_col_cnt == (i_width - c_ONE));
    assign w_row_end = (r_row_cnt == (i_height - c_HEIGHT_NB));

    // Decode uses the pre-increment position of the current beat
    assign o_emit = i_beat && (r_col_cnt >= c_FIRST_EMIT);
    assign o_last = o_emit && w_col_end && w_row_end;

    // Column/row counters; wrap at line end and at frame end
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (i_beat) begin
            if (w_col_end) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_end ? '0 : (r_row_cnt + c_ONE);
            end else begin
                r_col_cnt <= r_col_cnt + c_ONE;
            end
        end
    end

endmodule : window_pos
`default_nettype wire

// File: rtl/window.sv
`default_nettype none
// ============================================================================
//  Module      : window
//  Description : Builds a HEIGHT_NB x WIDTH_NB kernel window from the column
//                stream of the line-delay block and emits it only when it
//                lies entirely within one image line, tagging the final
//                window of each frame. Valid-only stream, no backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module window
    import window_pkg::*;
#(
    parameter int HEIGHT_NB  = 3,
    parameter int WIDTH_NB   = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [MEM_AWIDTH-1:0]                    cfg_width,
    input  logic [MEM_AWIDTH-1:0]                    cfg_height,
    input  logic                                     cfg_set,
    input  logic [IMG_WIDTH*HEIGHT_NB-1:0]           up_data,
    input  logic                                     up_val,
    output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0]  dn_data,
    output logic                                     dn_val,
    output logic                                     dn_last,
    output logic                                     cfg_err
);

    localparam int c_COL_W = IMG_WIDTH * HEIGHT_NB;
    localparam int c_WIN_W = c_COL_W * WIDTH_NB;

    state_t                r_state;
    logic [MEM_AWIDTH-1:0] r_width;
    logic [MEM_AWIDTH-1:0] r_height;
    logic [c_WIN_W-1:0]    r_win;
    logic [c_WIN_W-1:0]    w_win_next;
    logic                  w_cfg_ok;
    logic                  w_beat;
    logic                  w_emit;
    logic                  w_last;

    // A frame needs at least one full kernel in each dimension
    assign w_cfg_ok = (cfg_width  >= MEM_AWIDTH'(WIDTH_NB)) &&
                      (cfg_height >= MEM_AWIDTH'(HEIGHT_NB));

    // A cfg_set in the same cycle takes priority and drops the beat
    assign w_beat = (r_state == ST_RUN) && up_val && !cfg_set;

    // Column 0 is the newest column; older columns move to higher offsets.
    // Stale columns from the previous line are never masked here: the
    // position tracker simply suppresses emission until they have aged out.
    generate
        if (WIDTH_NB > 1) begin : g_shift
            assign w_win_next = {r_win[c_WIN_W-c_COL_W-1:0], up_data};
        end else begin : g_single
            assign w_win_next = up_data;
        end
    endgenerate

    window_pos #(
        .HEIGHT_NB  (HEIGHT_NB),
        .WIDTH_NB   (WIDTH_NB),
        .MEM_AWIDTH (MEM_AWIDTH)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (cfg_set),
        .i_beat   (w_beat),
        .i_width  (r_width),
        .i_height (r_height),
        .o_emit   (w_emit),
        .o_last   (w_last)
    );

    // Control FSM, config latch, window shift register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_width  <= '0;
            r_height <= '0;
            r_win    <= '0;
            cfg_err  <= 1'b0;
            dn_data  <= '0;
            dn_val   <= 1'b0;
            dn_last  <= 1'b0;
        end else if (cfg_set) begin
            r_width  <= cfg_width;
            r_height <= cfg_height;
            r_win    <= '0;
            dn_val   <= 1'b0;
            dn_last  <= 1'b0;
            cfg_err  <= !w_cfg_ok;
            r_state  <= w_cfg_ok ? ST_RUN : ST_IDLE;
        end else if (w_beat) begin
            r_win   <= w_win_next;
            dn_val  <= w_emit;
            dn_last <= w_last;
            if (w_emit) begin
                dn_data <= w_win_next;
            end
        end else begin
            dn_val  <= 1'b0;
            dn_last <= 1'b0;
        end
    end

endmodule : window
`default_nettype wire

// File: tb/tb_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window
//  Description : Directed self-checking bench for the kernel window builder
//                (HEIGHT_NB=3, WIDTH_NB=3, IMG_WIDTH=8, 5x4 image).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window;

    localparam int c_H  = 3;
    localparam int c_W  = 3;
    localparam int c_IW = 8;
    localparam int c_AW = 16;

    logic                      clk;
    logic                      rst;
    logic [c_AW-1:0]           cfg_width;
    logic [c_AW-1:0]           cfg_height;
    logic                      cfg_set;
    logic [c_IW*c_H-1:0]       up_data;
    logic                      up_val;
    logic [c_IW*c_H*c_W-1:0]   dn_data;
    logic                      dn_val;
    logic                      dn_last;
    logic                      cfg_err;

    int n_cmp;
    int n_err;

    // Beat i (1-based) of a 5x4 frame: windows after beats 3,4,5,8,9,10
    bit c_EXP_VAL [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    window #(
        .HEIGHT_NB  (c_H),
        .WIDTH_NB   (c_W),
        .IMG_WIDTH  (c_IW),
        .MEM_AWIDTH (c_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_set    (cfg_set),
        .up_data    (up_data),
        .up_val     (up_val),
        .dn_data    (dn_data),
        .dn_val     (dn_val),
        .dn_last    (dn_last),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column k = {k+0x20, k+0x10, k}; row 0 in the low byte
    function automatic logic [23:0] col(input int k);
        col = {8'(k + 32), 8'(k + 16), 8'(k)};
    endfunction

    // Window whose newest column is k: col0=k, col1=k-1, col2=k-2
    function automatic logic [71:0] win(input int k);
        win = {col(k - 2), col(k - 1), col(k)};
    endfunction

    // One clock with the given stream inputs; returns 1 time unit after edge
    task automatic step(input logic v, input logic [23:0] d);
        up_val  = v;
        up_data = d;
        @(posedge clk);
        #1;
        up_val  = 1'b0;
    endtask

    task automatic do_cfg(input int w, input int h);
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        cfg_set    = 1'b1;
        up_val     = 1'b0;
        @(posedge clk);
        #1;
        cfg_set    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (dn_val !== 1'b0 || dn_last !== 1'b0 || cfg_err !== 1'b0 || dn_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got val=%b last=%b err=%b data=%h, want all zero",
                     dn_val, dn_last, cfg_err, dn_data);
        end
        // Unconfigured block is idle and ignores beats
        for (int i = 0; i < 4; i++) begin
            step(1'b1, col(i));
            n_cmp++;
            if (dn_val !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle beat %0d: got dn_val=%b, want 0", i, dn_val);
            end
        end
    endtask

    task automatic test_basic();
        do_cfg(5, 4);
        n_cmp++;
        if (cfg_err !== 1'b0 || dn_val !== 1'b0) begin
            n_err++;
            $display("FAIL basic_cfg: got err=%b val=%b, want 0 0", cfg_err, dn_val);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i - 1));
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL basic_val beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i - 1)) begin
                    n_err++;
                    $display("FAIL basic_data beat %0d: got %h, want %h", i, dn_data, win(i - 1));
                end
            end
        end
    endtask

    task automatic test_second_frame();
        int nv;
        int nl;
        nv = 0;
        nl = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i + 9));
            if (dn_val === 1'b1) nv++;
            if (dn_last === 1'b1) nl++;
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL frame2_val beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i + 9)) begin
                    n_err++;
                    $display("FAIL frame2_data beat %0d: got %h, want %h", i, dn_data, win(i + 9));
                end
            end
        end
        n_cmp++;
        if (nv != 6 || nl != 1) begin
            n_err++;
            $display("FAIL frame2_count: got %0d windows %0d last, want 6 1", nv, nl);
        end
    endtask

    task automatic test_toggle();
        int nv;
        nv = 0;
        do_cfg(5, 4);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i - 1));
            if (dn_val === 1'b1) nv++;
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL toggle_val beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i - 1)) begin
                    n_err++;
                    $display("FAIL toggle_data beat %0d: got %h, want %h", i, dn_data, win(i - 1));
                end
            end
            step(1'b0, col(99));
            n_cmp++;
            if (dn_val !== 1'b0 || dn_last !== 1'b0) begin
                n_err++;
                $display("FAIL toggle_gap after beat %0d: got val=%b last=%b, want 0 0",
                         i, dn_val, dn_last);
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i - 1)) begin
                    n_err++;
                    $display("FAIL toggle_hold after beat %0d: got %h, want %h", i, dn_data, win(i - 1));
                end
            end
        end
        n_cmp++;
        if (nv != 6) begin
            n_err++;
            $display("FAIL toggle_count: got %0d windows, want 6", nv);
        end
    endtask

    task automatic test_bad_cfg();
        int nv;
        nv = 0;
        do_cfg(2, 4);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL badcfg_err: got cfg_err=%b, want 1", cfg_err);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, col(i));
            if (dn_val === 1'b1) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL badcfg_idle: got %0d windows, want 0", nv);
        end
        do_cfg(5, 2);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL badcfg_height: got cfg_err=%b, want 1", cfg_err);
        end
        do_cfg(5, 4);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL badcfg_clear: got cfg_err=%b, want 0", cfg_err);
        end
        nv = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i - 1));
            if (dn_val === 1'b1) nv++;
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL badcfg_recover beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
        end
        n_cmp++;
        if (nv != 6) begin
            n_err++;
            $display("FAIL badcfg_count: got %0d windows, want 6", nv);
        end
    endtask

    task automatic test_cfg_drop();
        int nv;
        do_cfg(5, 4);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, col(50 + i));
        end
        // Beat 4 collides with cfg_set and must be dropped
        cfg_set = 1'b1;
        step(1'b1, col(60));
        cfg_set = 1'b0;
        n_cmp++;
        if (dn_val !== 1'b0 || dn_last !== 1'b0) begin
            n_err++;
            $display("FAIL drop_clear: got val=%b last=%b, want 0 0", dn_val, dn_last);
        end
        nv = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i - 1));
            if (dn_val === 1'b1) nv++;
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL drop_val beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i - 1)) begin
                    n_err++;
                    $display("FAIL drop_data beat %0d: got %h, want %h", i, dn_data, win(i - 1));
                end
            end
        end
        n_cmp++;
        if (nv != 6) begin
            n_err++;
            $display("FAIL drop_count: got %0d windows, want 6", nv);
        end
    endtask

    task automatic test_rst_midframe();
        int nv;
        do_cfg(5, 4);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, col(i - 1));
        end
        rst = 1'b1;
        step(1'b0, col(0));
        rst = 1'b0;
        n_cmp++;
        if (dn_val !== 1'b0 || dn_last !== 1'b0 || cfg_err !== 1'b0 || dn_data !== '0) begin
            n_err++;
            $display("FAIL rst_outputs: got val=%b last=%b err=%b data=%h, want all zero",
                     dn_val, dn_last, cfg_err, dn_data);
        end
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, col(i));
            if (dn_val === 1'b1) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL rst_idle: got %0d windows, want 0", nv);
        end
        do_cfg(5, 4);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, col(i + 69));
            n_cmp++;
            if (dn_val !== c_EXP_VAL[i-1] || dn_last !== (i == 10)) begin
                n_err++;
                $display("FAIL rst_restart beat %0d: got val=%b last=%b, want %b %b",
                         i, dn_val, dn_last, c_EXP_VAL[i-1], (i == 10));
            end
            if (c_EXP_VAL[i-1]) begin
                n_cmp++;
                if (dn_data !== win(i + 69)) begin
                    n_err++;
                    $display("FAIL rst_data beat %0d: got %h, want %h", i, dn_data, win(i + 69));
                end
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        cfg_width  = '0;
        cfg_height = '0;
        cfg_set    = 1'b0;
        up_data    = '0;
        up_val     = 1'b0;
        test_reset();
        test_basic();
        test_second_frame();
        test_toggle();
        test_bad_cfg();
        test_cfg_drop();
        test_rst_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_window
`default_nettype wire
